// File: rtl/ddr_wr_burst.sv
// ddr_wr_burst -- drains a sync FIFO into fixed-length DDR write bursts.
//
// The block shadows the FIFO occupancy from its write/read strobes. Once a
// full burst is available it issues one command (address + length) and then
// streams exactly BURST_LEN words onto the write-data channel, the last one
// flagged with wlast. Burst addresses walk a frame buffer of FRAME_WORDS
// words starting at BASE_ADDR and wrap at its end; frame_start rewinds the
// address to BASE_ADDR.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   fifo_wr_en/full      monitored upstream FIFO write strobe and full flag
//   fifo_rd_en           FIFO read strobe (data arrives one cycle later)
//   fifo_rd_data         FIFO read data
//   frame_start          1-cycle pulse: restart the frame-buffer address
//   cmd_valid/ready      burst command handshake
//   cmd_addr/len         burst word address, burst length minus one
//   wvalid/ready         write-data handshake
//   wdata/wlast          write data, last word of the burst
//   busy                 high whenever a burst is being commanded or written
module ddr_wr_burst #(
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_LEN   = 8,
  parameter int ADDR_WIDTH  = 28,
  parameter int BASE_ADDR   = 0,
  parameter int FRAME_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_wr_en,
  input  logic                  fifo_full,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  input  logic                  frame_start,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_addr,
  output logic [7:0]            cmd_len,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic                  wlast,
  output logic                  busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  localparam logic [4:0]            LVL_BURST = 5'(BURST_LEN);
  localparam logic [CNT_W-1:0]      CNT_BURST = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(BURST_LEN - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_BASE = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH-1:0] ADDR_END  = ADDR_WIDTH'(BASE_ADDR + FRAME_WORDS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(BURST_LEN);
  localparam logic [7:0]            LEN_FIELD = 8'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e                  state_q;
  logic                    busy_q;
  logic                    cmd_valid_q;
  logic [ADDR_WIDTH-1:0]   cmd_addr_q;
  logic [7:0]              cmd_len_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    fs_pend_q;

  logic [4:0]              level_q;
  logic [4:0]              level_d;
  logic [CNT_W-1:0]        rd_cnt_q;
  logic [CNT_W-1:0]        beat_cnt_q;

  // Skid buffer: the word returning from the FIFO (inflight_q) is presented
  // directly when the buffer is empty, and parked in the buffer otherwise or
  // when the sink stalls, so the head never changes while stalled.
  logic                    inflight_q;
  logic [DATA_WIDTH-1:0]   buf_q [2];
  logic [1:0]              buf_cnt_q;
  logic [1:0]              buf_cnt_d;
  logic                    buf_wr_ptr_q;
  logic                    buf_rd_ptr_q;

  logic                    w_hs;
  logic                    burst_done;
  logic                    buf_push;
  logic                    buf_pop;
  logic [2:0]              occ_next;
  logic [ADDR_WIDTH-1:0]   addr_inc;

  // ---------------------------------------------------------------------
  // Write-data channel
  // ---------------------------------------------------------------------
  assign wvalid     = (buf_cnt_q != 2'd0) || inflight_q;
  assign wdata      = (buf_cnt_q != 2'd0) ? buf_q[buf_rd_ptr_q] :
                      inflight_q          ? fifo_rd_data        : '0;
  assign wlast      = wvalid && (beat_cnt_q == CNT_LAST);
  assign w_hs       = wvalid && wready;
  assign burst_done = w_hs && wlast;

  assign buf_push = inflight_q && !((buf_cnt_q == 2'd0) && w_hs);
  assign buf_pop  = w_hs && (buf_cnt_q != 2'd0);

  // Words held or arriving next cycle once this cycle's beat leaves; a new
  // read is only allowed when it will still fit in the two entries.
  assign occ_next   = 3'(buf_cnt_q) + 3'(inflight_q) - 3'(w_hs);
  assign fifo_rd_en = (state_q == DATA) && (level_q != 5'd0) &&
                      (rd_cnt_q < CNT_BURST) && (occ_next < 3'd2);

  // ---------------------------------------------------------------------
  // Command channel / status
  // ---------------------------------------------------------------------
  assign cmd_valid = cmd_valid_q;
  assign cmd_addr  = cmd_addr_q;
  assign cmd_len   = cmd_len_q;
  assign busy      = busy_q;

  assign addr_inc = addr_q + ADDR_STEP;
  assign addr_d   = (addr_inc == ADDR_END) ? ADDR_BASE : addr_inc;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    level_d = level_q;
    unique case ({fifo_wr_en && !fifo_full, fifo_rd_en})
      2'b10:   level_d = level_q + 5'd1;
      2'b01:   level_d = level_q - 5'd1;
      default: level_d = level_q;
    endcase

    buf_cnt_d = buf_cnt_q + 2'(buf_push) - 2'(buf_pop);
  end

  // ---------------------------------------------------------------------
  // Burst sequencer
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
      addr_q      <= ADDR_BASE;
      fs_pend_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (frame_start) addr_q <= ADDR_BASE;
          if (level_q >= LVL_BURST) begin
            state_q     <= CMD;
            busy_q      <= 1'b1;
            cmd_valid_q <= 1'b1;
            cmd_addr_q  <= frame_start ? ADDR_BASE : addr_q;
            cmd_len_q   <= LEN_FIELD;
          end
        end
        CMD: begin
          if (frame_start) fs_pend_q <= 1'b1;
          if (cmd_ready) begin
            state_q     <= DATA;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_len_q   <= '0;
          end
        end
        DATA: begin
          if (burst_done) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            // A frame restart seen during the burst replaces the increment.
            addr_q    <= (fs_pend_q || frame_start) ? ADDR_BASE : addr_d;
            fs_pend_q <= 1'b0;
          end else if (frame_start) begin
            fs_pend_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          busy_q      <= 1'b0;
          cmd_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Occupancy, burst counters and skid-buffer control
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q      <= '0;
      rd_cnt_q     <= '0;
      beat_cnt_q   <= '0;
      inflight_q   <= 1'b0;
      buf_cnt_q    <= '0;
      buf_wr_ptr_q <= 1'b0;
      buf_rd_ptr_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      inflight_q <= fifo_rd_en;
      buf_cnt_q  <= buf_cnt_d;
      if (buf_push) buf_wr_ptr_q <= ~buf_wr_ptr_q;
      if (buf_pop)  buf_rd_ptr_q <= ~buf_rd_ptr_q;

      if (state_q == CMD) begin
        rd_cnt_q   <= '0;
        beat_cnt_q <= '0;
      end else begin
        if (fifo_rd_en) rd_cnt_q   <= rd_cnt_q + 1'b1;
        if (w_hs)       beat_cnt_q <= beat_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: buffer storage is deliberately not reset; it is only observed
  // through wdata, which is forced to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (buf_push) buf_q[buf_wr_ptr_q] <= fifo_rd_data;
  end

endmodule

// File: tb/tb_ddr_wr_burst.sv
// tb_ddr_wr_burst -- directed self-checking bench for ddr_wr_burst.
//
// A queue models the upstream FIFO (data one cycle after fifo_rd_en, a
// poison value otherwise). Inputs change 1 time unit after the rising edge;
// the monitors sample on the falling edge.
module tb_ddr_wr_burst;

  localparam int DW = 32;
  localparam int AW = 28;
  localparam logic [DW-1:0] POISON = 32'hBAD0_BAD0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fifo_wr_en;
  logic          fifo_full;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data;
  logic          frame_start;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic          wvalid;
  logic          wready;
  logic [DW-1:0] wdata;
  logic          wlast;
  logic          busy;

  logic [DW-1:0] wr_word;
  logic [DW-1:0] fq[$];
  logic [DW-1:0] got_data[$];
  bit            got_last[$];
  int            underflows = 0;
  int            hold_errs  = 0;
  int            checks     = 0;
  int            failures   = 0;

  always #5 clk = ~clk;

  ddr_wr_burst #(
    .DATA_WIDTH (DW),
    .BURST_LEN  (8),
    .ADDR_WIDTH (AW),
    .BASE_ADDR  (0),
    .FRAME_WORDS(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_full   (fifo_full),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .frame_start (frame_start),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_addr    (cmd_addr),
    .cmd_len     (cmd_len),
    .wvalid      (wvalid),
    .wready      (wready),
    .wdata       (wdata),
    .wlast       (wlast),
    .busy        (busy)
  );

  // Upstream FIFO model, sharing the reset with the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      fifo_rd_data <= POISON;
    end else begin
      if (fifo_rd_en && fq.size() != 0) fifo_rd_data <= fq.pop_front();
      else                              fifo_rd_data <= POISON;
      if (fifo_wr_en && !fifo_full) fq.push_back(wr_word);
    end
  end

  // Beat collector, stall-hold and underflow monitor.
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data;
  logic          prev_last;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (fifo_rd_en && fq.size() == 0) underflows++;
      if (prev_stall && (!wvalid || wdata !== prev_data || wlast !== prev_last))
        hold_errs++;
      if (wvalid && wready) begin
        got_data.push_back(wdata);
        got_last.push_back(wlast);
      end
      prev_stall = wvalid && !wready;
      prev_data  = wdata;
      prev_last  = wlast;
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_words(input logic [DW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_wr_en = 1'b1;
      wr_word    = base + DW'(i);
      tick();
    end
    fifo_wr_en = 1'b0;
  endtask

  task automatic wait_cmd(input string tag);
    int n = 0;
    while (!cmd_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_cmd_seen"}, 64'(cmd_valid), 64'd1);
  endtask

  // Writes a burst's worth of words, waits for the command and checks it,
  // and returns in the first DATA cycle.
  task automatic start_burst(input string tag, input logic [DW-1:0] base,
                             input logic [AW-1:0] exp_addr, input bit fs_coincide);
    write_words(base, 8);
    if (fs_coincide) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
    end
    wait_cmd(tag);
    check({tag, "_cmd_addr"}, 64'(cmd_addr), 64'(exp_addr));
    check({tag, "_cmd_len"},  64'(cmd_len),  64'd7);
    if (!cmd_ready) begin
      tick();
      tick();
      check({tag, "_cmd_hold_valid"}, 64'(cmd_valid), 64'd1);
      check({tag, "_cmd_hold_addr"},  64'(cmd_addr),  64'(exp_addr));
      cmd_ready = 1'b1;
    end
    tick();
  endtask

  task automatic finish_burst(input string tag, input bit toggle, output int cyc);
    cyc = 0;
    while (busy && cyc < 100) begin
      tick();
      if (toggle) wready = ~wready;
      cyc++;
    end
    check({tag, "_idle"}, 64'(busy), 64'd0);
    wready = 1'b1;
  endtask

  task automatic check_beats(input string tag, input logic [DW-1:0] base);
    logic [7:0] last_mask = '0;
    check({tag, "_beats"}, 64'(got_data.size()), 64'd8);
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      check($sformatf("%s_d%0d", tag, i), 64'(got_data[i]), 64'(base + DW'(i)));
      last_mask[i] = got_last[i];
    end
    check({tag, "_wlast"}, 64'(last_mask), 64'h80);
    got_data.delete();
    got_last.delete();
  endtask

  initial begin
    int  cyc;
    bit  seen;

    rst_n       = 1'b0;
    fifo_wr_en  = 1'b0;
    fifo_full   = 1'b0;
    wr_word     = '0;
    frame_start = 1'b0;
    cmd_ready   = 1'b1;
    wready      = 1'b1;

    // Reset state
    tick();
    tick();
    check("rst_busy",      64'(busy),       64'd0);
    check("rst_cmd_valid", 64'(cmd_valid),  64'd0);
    check("rst_wvalid",    64'(wvalid),     64'd0);
    check("rst_rd_en",     64'(fifo_rd_en), 64'd0);
    check("rst_wdata",     64'(wdata),      64'd0);
    rst_n = 1'b1;
    tick();

    // Seven words are not enough for a burst; the eighth is.
    write_words(32'h100, 7);
    seen = 1'b0;
    repeat (5) begin
      tick();
      if (cmd_valid) seen = 1'b1;
    end
    check("b1_no_cmd_at_7", 64'(seen), 64'd0);
    write_words(32'h107, 1);
    check("b1_cmd_not_yet", 64'(cmd_valid), 64'd0);
    tick();
    check("b1_cmd_valid", 64'(cmd_valid), 64'd1);
    check("b1_cmd_addr",  64'(cmd_addr),  64'd0);
    check("b1_cmd_len",   64'(cmd_len),   64'd7);
    check("b1_busy",      64'(busy),      64'd1);
    tick();
    check("b1_d0_rd_en",  64'(fifo_rd_en), 64'd1);
    check("b1_d0_wvalid", 64'(wvalid),     64'd0);
    tick();
    check("b1_d1_wvalid", 64'(wvalid), 64'd1);
    check("b1_d1_wdata",  64'(wdata),  64'h100);
    finish_burst("b1", 1'b0, cyc);
    check("b1_data_cycles", 64'(cyc + 1), 64'd9);
    check_beats("b1", 32'h100);

    // Second burst at 8 with a delayed cmd_ready and wready toggling.
    cmd_ready = 1'b0;
    start_burst("b2", 32'h200, 28'd8, 1'b0);
    finish_burst("b2", 1'b1, cyc);
    check_beats("b2", 32'h200);
    check("b2_hold_errs", 64'(hold_errs), 64'd0);

    // Address wraps at the end of the 16-word frame.
    start_burst("b3", 32'h300, 28'd0, 1'b0);
    finish_burst("b3", 1'b0, cyc);
    check_beats("b3", 32'h300);

    // frame_start mid-DATA of the burst at 8, then of a burst at 0.
    start_burst("b4", 32'h400, 28'd8, 1'b0);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    finish_burst("b4", 1'b0, cyc);
    check_beats("b4", 32'h400);

    start_burst("b5", 32'h500, 28'd0, 1'b0);
    tick();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    finish_burst("b5", 1'b0, cyc);
    check_beats("b5", 32'h500);

    start_burst("b6", 32'h600, 28'd0, 1'b0);
    finish_burst("b6", 1'b0, cyc);
    check_beats("b6", 32'h600);

    // frame_start coinciding with IDLE -> CMD overrides the pending address 8.
    start_burst("b7", 32'h700, 28'd0, 1'b1);
    finish_burst("b7", 1'b0, cyc);
    check_beats("b7", 32'h700);

    // Reset on the fourth beat of the burst at 8.
    start_burst("b8", 32'h800, 28'd8, 1'b0);
    cyc = 0;
    while (got_data.size() < 3 && cyc < 20) begin
      tick();
      cyc++;
    end
    check("b8_beat4_wvalid", 64'(wvalid), 64'd1);
    check("b8_beat4_wdata",  64'(wdata),  64'h803);
    rst_n = 1'b0;
    #1;
    check("b8_rst_ctl", 64'({fifo_rd_en, cmd_valid, wvalid, wlast, busy}), 64'd0);
    check("b8_rst_wdata",    64'(wdata),    64'd0);
    check("b8_rst_cmd_addr", 64'(cmd_addr), 64'd0);
    check("b8_rst_cmd_len",  64'(cmd_len),  64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    got_data.delete();
    got_last.delete();
    repeat (10) tick();
    check("b8_no_beats_after_rst", 64'(got_data.size()), 64'd0);
    check("b8_idle_after_rst",     64'(busy),            64'd0);

    start_burst("b9", 32'h900, 28'd0, 1'b0);
    finish_burst("b9", 1'b0, cyc);
    check_beats("b9", 32'h900);

    check("fifo_drained",    64'(fq.size()),  64'd0);
    check("fifo_underflows", 64'(underflows), 64'd0);
    check("stall_hold_errs", 64'(hold_errs),  64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
